// File: rtl/matrix_pkg.sv
// Shared types and defaults for the systolic-array result path.
package matrix_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_COLLECT,
        WR_DRAIN,
        WR_DONE
    } wr_state_t;

    localparam int unsigned RESULT_HEAD_ADDR_DEFAULT = 'h200;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result buffer; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [DATA_WIDTH-1:0]         head,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/mat_result_writer.sv
// Buffers one burst of PE results and writes them to consecutive result-memory
// addresses over a valid/ready port, pulsing done when the burst has drained.
module mat_result_writer
    import matrix_pkg::*;
#(
    parameter int          DATA_WIDTH       = 32,
    parameter int          ADDR_SIZE        = 10,
    parameter int          FIFO_DEPTH       = 16,
    parameter int unsigned RESULT_HEAD_ADDR = RESULT_HEAD_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic [7:0]            column_size,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_SIZE-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_SIZE-1:0] HEAD = ADDR_SIZE'(RESULT_HEAD_ADDR);

    // Write port: a transfer happens in any cycle with wr_valid && wr_ready.
    // wr_valid never drops and wr_addr/wr_data never change until that transfer.

    wr_state_t             state, state_next;
    logic [7:0]            n, n_start, in_cnt, out_cnt;
    logic                  push, pop, drop, start;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CW-1:0]         fifo_count;

    result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (res_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign wr_valid  = !fifo_empty && (state == WR_COLLECT || state == WR_DRAIN);
    assign pop       = wr_valid && wr_ready;
    assign wr_addr   = wr_valid ? HEAD + ADDR_SIZE'(out_cnt) : '0;
    assign wr_data   = wr_valid ? fifo_head : '0;
    assign busy      = (state != WR_IDLE);
    assign done      = (state == WR_DONE);
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        drop       = 1'b0;
        start      = 1'b0;
        n_start    = (column_size == 8'd0) ? 8'd1 : column_size;
        case (state)
            WR_IDLE: begin
                if (read) begin
                    start      = 1'b1;
                    push       = 1'b1;
                    state_next = (n_start == 8'd1) ? WR_DRAIN : WR_COLLECT;
                end
            end
            WR_COLLECT: begin
                if (read) begin
                    if (fifo_full && !pop) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (in_cnt + 8'd1 == n) state_next = WR_DRAIN;
                    end
                end else begin
                    state_next = WR_DRAIN;
                end
            end
            WR_DRAIN: begin
                drop = read;
                // Leave as the final word is accepted so done lands one cycle later.
                if ((fifo_empty || (pop && fifo_count == CW'(1))) &&
                    (out_cnt + {7'd0, pop} == in_cnt)) begin
                    state_next = WR_DONE;
                end
            end
            WR_DONE: begin
                drop       = read;
                state_next = WR_IDLE;
            end
            default: state_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WR_IDLE;
            n        <= 8'd0;
            in_cnt   <= 8'd0;
            out_cnt  <= 8'd0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                n        <= n_start;
                in_cnt   <= 8'd1;
                out_cnt  <= 8'd0;
                overflow <= 1'b0;
            end else begin
                if (push) in_cnt   <= in_cnt + 8'd1;
                if (pop)  out_cnt  <= out_cnt + 8'd1;
                if (drop) overflow <= 1'b1;
            end
        end
    end

endmodule
